inpass4_event_arbiter: RTL and testbench
========================================

INPASS4_EVENT_ARBITER -- requirements
Module: inpass4_event_arbiter

Interface
REQ-001 Parameter: NoConfigBits, default 4, number of global configuration bits; one lane-enable bit per lane.
REQ-002 Parameter: CNT_W, default 3, width of each lane's pending-event counter.
REQ-003 Port: UserCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: resetn  input  1  reset, synchronous, active-low.
REQ-005 Port: I  input  4  external input lanes; all four lanes are requesters.
REQ-006 Port: ConfigBits  input  NoConfigBits  global config; bit k = 1 enables lane k.
REQ-007 Port: O  output  4  registered copy of I.
REQ-008 Port: out_valid  output  1  granted event present.
REQ-009 Port: out_ready  input  1  consumer accepts the event.
REQ-010 Port: out_lane  output  2  index of the granted lane.
REQ-011 Port: busy  output  1  high when any pending counter is nonzero or out_valid is high.
REQ-012 Port: ovf  output  4  sticky per-lane overflow flags.

Function
REQ-013 The block SHALL register I into I_q on every clock and drive O = I_q.
REQ-014 Lane k event SHALL be: I[k]=1 and I_q[k]=0 and ConfigBits[k]=1, evaluated at the same clock edge.
REQ-015 On an event, pend[k] SHALL increment at that edge and saturate at 2^CNT_W-1.
REQ-016 An event arriving while pend[k] is saturated SHALL set ovf[k]; ovf[k] SHALL stay set until reset.
REQ-017 The output slot SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-018 When the slot is free and any enabled pend[k] is nonzero, the block SHALL grant one lane at that edge: out_valid<=1, out_lane<=k, pend[k] decremented by 1.
REQ-019 The grant search SHALL be round-robin, starting at lane (last_grant+1) mod 4 and wrapping; last_grant SHALL update only on a grant.
REQ-020 When the slot is free and no lane is eligible, out_valid SHALL go to 0 at that edge.
REQ-021 out_valid and out_lane SHALL hold steady while out_valid=1 and out_ready=0.
REQ-022 Latency: event at edge c makes out_valid=1 after edge c+1 at the earliest; sustained throughput is one grant per cycle while out_ready=1.
REQ-023 An increment and a grant-decrement on the same lane at the same edge SHALL leave pend[k] unchanged; saturation SHALL be evaluated after the net update, so ovf is not set in this case.
REQ-024 Clearing ConfigBits[k] SHALL clear pend[k] at the next edge and exclude lane k from arbitration.
REQ-025 Clearing ConfigBits[k] SHALL NOT cancel an event for lane k already in the output slot.
REQ-026 ConfigBits SHALL NOT affect O or ovf, except that ovf cannot newly set while the lane is disabled.
REQ-027 busy SHALL be combinational from the registered state.

Reset
REQ-028 With resetn=0 at an edge, the block SHALL force I_q=0, O=0, pend=0 on all lanes, out_valid=0, out_lane=0, last_grant=3, and ovf=0.
REQ-029 Reset SHALL take priority over events and handshakes at the same edge.
REQ-030 Reset asserted mid-transfer SHALL drop the pending output and all counted events.
REQ-031 After resetn returns to 1, a lane already high SHALL produce an event at the first active edge, because I_q was cleared to 0.

Verification
REQ-032 ConfigBits=4'hF, out_ready=1; I goes 0000->0001 at edge 5 -> out_valid=1, out_lane=0 after edge 6; out_valid=0 after edge 7; busy goes low.
REQ-033 ConfigBits=4'hF, out_ready=0; I goes 0000->1111 in one cycle; then out_ready=1 -> grants in order 0,1,2,3 on consecutive cycles, then out_valid=0.
REQ-034 CNT_W=3, out_ready=0; pulse I[2] nine times -> pend[2]=7 and ovf[2]=1; then out_ready=1 -> exactly 7 grants of lane 2; ovf[2] stays 1.
REQ-035 ConfigBits=4'b0100; events arrive on all lanes -> only lane 2 is granted and pend stays 0 for the others; clear bit 2 while lane 2 is in the slot -> the slot event is still delivered, pend[2] is cleared, and no further grants occur.
REQ-036 Pend[1]=1 and out_valid=1 with out_ready=1, and a new I[1] edge arrives at the same edge -> pend[1] stays 1 and ovf[1] stays 0.
REQ-037 resetn=0 for one edge while out_valid=1 and pend nonzero -> all outputs are 0 and ovf=0 next cycle; with I=1111 held, events appear on all lanes at the first edge after release.

Source files
------------

// File: rtl/inpass4_event_arbiter.sv
// Four-lane rising-edge event counter with a round-robin arbiter feeding a
// single valid/ready output slot. Lanes are individually enabled by ConfigBits.
module inpass4_event_arbiter #(
    parameter int unsigned NoConfigBits = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                    UserCLK,
    input  logic                    resetn,
    input  logic [3:0]              I,
    input  logic [NoConfigBits-1:0] ConfigBits,
    output logic [3:0]              O,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_lane,
    output logic                    busy,
    output logic [3:0]              ovf
);

    localparam int unsigned NL     = 4;
    localparam int unsigned LANE_W = 2;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [NL-1:0]             in_q, in_d;
    logic [NL-1:0][CNT_W-1:0]  pend_q, pend_d;
    logic [NL-1:0]             ovf_q, ovf_d;
    logic                      out_valid_q, out_valid_d;
    logic [LANE_W-1:0]         out_lane_q, out_lane_d;
    logic [LANE_W-1:0]         last_grant_q, last_grant_d;

    logic [NL-1:0]     lane_en;
    logic [NL-1:0]     ev;
    logic [NL-1:0]     eligible;
    logic              slot_free;
    logic              grant_vld;
    logic [LANE_W-1:0] grant_lane;
    logic [LANE_W-1:0] idx;
    logic              do_grant;
    logic              dec;

    assign lane_en   = ConfigBits[NL-1:0];
    assign ev        = I & ~in_q & lane_en;
    assign slot_free = ~out_valid_q | out_ready;

    always_comb begin
        for (int unsigned k = 0; k < NL; k++) begin
            eligible[k] = lane_en[k] & (pend_q[k] != '0);
        end
    end

    // Round-robin search starting just after the last granted lane
    always_comb begin
        grant_vld  = 1'b0;
        grant_lane = last_grant_q;
        idx        = '0;
        for (int unsigned i = 1; i <= NL; i++) begin
            idx = last_grant_q + LANE_W'(i);
            if (!grant_vld && eligible[idx]) begin
                grant_vld  = 1'b1;
                grant_lane = idx;
            end
        end
    end

    assign do_grant = slot_free & grant_vld;

    always_comb begin
        in_d         = I;
        pend_d       = pend_q;
        ovf_d        = ovf_q;
        out_valid_d  = out_valid_q;
        out_lane_d   = out_lane_q;
        last_grant_d = last_grant_q;
        dec          = 1'b0;

        if (slot_free) begin
            out_valid_d = grant_vld;
        end
        if (do_grant) begin
            out_lane_d   = grant_lane;
            last_grant_d = grant_lane;
        end

        // Net counter update: a simultaneous increment and decrement cancel
        for (int unsigned k = 0; k < NL; k++) begin
            dec = do_grant && (grant_lane == LANE_W'(k));
            if (!lane_en[k]) begin
                pend_d[k] = '0;
            end else if (ev[k] && !dec) begin
                if (pend_q[k] == PEND_MAX) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    pend_d[k] = pend_q[k] + CNT_W'(1);
                end
            end else if (!ev[k] && dec) begin
                pend_d[k] = pend_q[k] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            in_q         <= '0;
            pend_q       <= '0;
            ovf_q        <= '0;
            out_valid_q  <= 1'b0;
            out_lane_q   <= '0;
            last_grant_q <= LANE_W'(NL - 1);
        end else begin
            in_q         <= in_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            out_valid_q  <= out_valid_d;
            out_lane_q   <= out_lane_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign O         = in_q;
    assign out_valid = out_valid_q;
    assign out_lane  = out_lane_q;
    assign ovf       = ovf_q;
    assign busy      = out_valid_q | (|pend_q);

endmodule

// File: tb/tb_inpass4_event_arbiter.sv
// Bench for inpass4_event_arbiter: directed vector table, corner-case sequences
// and random stimulus against an integer-level reference model.
module tb_inpass4_event_arbiter;

    localparam int CNT_W = 3;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic       UserCLK;
    logic       resetn;
    logic [3:0] I;
    logic [3:0] ConfigBits;
    logic [3:0] O;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_lane;
    logic       busy;
    logic [3:0] ovf;

    inpass4_event_arbiter #(.NoConfigBits(4), .CNT_W(CNT_W)) dut (
        .UserCLK   (UserCLK),
        .resetn    (resetn),
        .I         (I),
        .ConfigBits(ConfigBits),
        .O         (O),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int         m_pend[4];
    bit         m_ovf[4];
    bit         m_valid;
    int         m_lane;
    int         m_last;
    bit [3:0]   m_iq;

    int hs_count;
    int hs_lane2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit [3:0] i, input bit [3:0] c, input bit rd);
        bit [3:0] ev;
        int gl;
        int net;
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                m_pend[k] = 0;
                m_ovf[k]  = 0;
            end
            m_valid = 0;
            m_lane  = 0;
            m_last  = 3;
            m_iq    = '0;
            return;
        end
        for (int k = 0; k < 4; k++) ev[k] = i[k] && !m_iq[k] && c[k];
        gl = -1;
        if (!m_valid || rd) begin
            for (int s = 1; s <= 4; s++) begin
                int l;
                l = (m_last + s) % 4;
                if (gl < 0 && c[l] && m_pend[l] > 0) gl = l;
            end
            if (gl >= 0) begin
                m_valid = 1;
                m_lane  = gl;
                m_last  = gl;
            end else begin
                m_valid = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (!c[k]) begin
                m_pend[k] = 0;
            end else begin
                net = m_pend[k] + int'(ev[k]) - ((gl == k) ? 1 : 0);
                if (net > PMAX) begin
                    m_pend[k] = PMAX;
                    m_ovf[k]  = 1;
                end else begin
                    m_pend[k] = net;
                end
            end
        end
        m_iq = i;
    endtask

    function automatic bit m_busy();
        bit b;
        b = m_valid;
        for (int k = 0; k < 4; k++) if (m_pend[k] > 0) b = 1;
        return b;
    endfunction

    function automatic logic [3:0] m_ovf_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_ovf[k];
        return v;
    endfunction

    // One clock: drive, advance model, compare all outputs against the model
    task automatic step(input logic r, input logic [3:0] i, input logic [3:0] c, input logic rd);
        resetn = r; I = i; ConfigBits = c; out_ready = rd;
        if (r && out_valid && rd) begin
            hs_count++;
            if (out_lane == 2'd2) hs_lane2++;
        end
        @(posedge UserCLK);
        model_edge(r, i, c, rd);
        #1;
        chk("model_O", 32'(O), 32'(m_iq));
        chk("model_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid || !r) chk("model_lane", 32'(out_lane), 32'(m_lane));
        chk("model_busy", 32'(busy), 32'(m_busy()));
        chk("model_ovf", 32'(ovf), 32'(m_ovf_vec()));
    endtask

    typedef struct {
        logic       rstn;
        logic [3:0] i;
        logic [3:0] cfg;
        logic       rdy;
        logic       e_valid;
        logic [1:0] e_lane;
        logic       e_busy;
        logic [3:0] e_ovf;
        logic [3:0] e_o;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        hs_count = 0;
        hs_lane2 = 0;
        resetn = 1'b0; I = '0; ConfigBits = 4'hF; out_ready = 1'b0;

        // Single event latency, then a burst of four lanes drained in order
        tbl[0]  = '{1'b0, 4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0001, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0, 4'b0001};
        tbl[2]  = '{1'b1, 4'b0001, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0, 4'b0001};
        tbl[3]  = '{1'b1, 4'b0001, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0001};
        tbl[4]  = '{1'b0, 4'b0000, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0000};
        tbl[5]  = '{1'b1, 4'b1111, 4'hF, 1'b0, 1'b0, 2'd0, 1'b1, 4'h0, 4'b1111};
        tbl[6]  = '{1'b1, 4'b1111, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0, 4'b1111};
        tbl[7]  = '{1'b1, 4'b1111, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0, 4'b1111};
        tbl[8]  = '{1'b1, 4'b1111, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'h0, 4'b1111};
        tbl[9]  = '{1'b1, 4'b1111, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0, 4'b1111};
        tbl[10] = '{1'b1, 4'b1111, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 4'h0, 4'b1111};
        tbl[11] = '{1'b1, 4'b1111, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'b1111};

        for (int v = 0; v < 12; v++) begin
            step(tbl[v].rstn, tbl[v].i, tbl[v].cfg, tbl[v].rdy);
            chk($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'(tbl[v].e_valid));
            if (tbl[v].e_valid || !tbl[v].rstn)
                chk($sformatf("tbl%0d_lane", v), 32'(out_lane), 32'(tbl[v].e_lane));
            chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].e_busy));
            chk($sformatf("tbl%0d_ovf", v), 32'(ovf), 32'(tbl[v].e_ovf));
            chk($sformatf("tbl%0d_O", v), 32'(O), 32'(tbl[v].e_o));
        end

        // Saturation: nine pulses on lane 2 with the consumer stalled
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        for (int p = 0; p < 9; p++) begin
            step(1'b1, 4'b0100, 4'hF, 1'b0);
            step(1'b1, 4'b0000, 4'hF, 1'b0);
        end
        chk("sat_ovf", 32'(ovf), 32'h4);
        hs_count = 0;
        hs_lane2 = 0;
        for (int n = 0; n < 20; n++) step(1'b1, 4'b0000, 4'hF, 1'b1);
        chk("sat_handshakes", 32'(hs_count), 32'd8);
        chk("sat_lane2", 32'(hs_lane2), 32'd8);
        chk("sat_ovf_sticky", 32'(ovf), 32'h4);
        chk("sat_idle", 32'(busy), 32'd0);

        // Only lane 2 enabled; disable it while it owns the slot
        step(1'b0, 4'b0000, 4'b0100, 1'b0);
        step(1'b1, 4'b1111, 4'b0100, 1'b0);
        step(1'b1, 4'b1111, 4'b0100, 1'b0);
        chk("en_slot_lane", 32'(out_lane), 32'd2);
        step(1'b1, 4'b0000, 4'b0100, 1'b0);
        step(1'b1, 4'b1111, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        chk("dis_slot_kept", 32'(out_valid), 32'd1);
        step(1'b1, 4'b0000, 4'b0000, 1'b1);
        chk("dis_no_regrant", 32'(out_valid), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);

        // Increment and grant-decrement of lane 1 on the same edge
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        step(1'b1, 4'b0010, 4'hF, 1'b0);
        step(1'b1, 4'b0000, 4'hF, 1'b0);
        step(1'b1, 4'b0010, 4'hF, 1'b0);
        step(1'b1, 4'b0000, 4'hF, 1'b0);
        step(1'b1, 4'b0010, 4'hF, 1'b1);
        chk("net_ovf", 32'(ovf), 32'd0);
        chk("net_valid", 32'(out_valid), 32'd1);
        step(1'b1, 4'b0010, 4'hF, 1'b1);
        chk("net_second_grant", 32'(out_valid), 32'd1);
        step(1'b1, 4'b0010, 4'hF, 1'b1);
        chk("net_drained", 32'(out_valid), 32'd0);

        // Reset mid-transfer, then events from lanes held high
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        step(1'b1, 4'b1111, 4'hF, 1'b0);
        step(1'b1, 4'b1111, 4'hF, 1'b0);
        step(1'b0, 4'b1111, 4'hF, 1'b1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_O", 32'(O), 32'd0);
        step(1'b1, 4'b1111, 4'hF, 1'b1);
        chk("rel_busy", 32'(busy), 32'd1);
        step(1'b1, 4'b1111, 4'hF, 1'b1);
        chk("rel_lane0", 32'(out_lane), 32'd0);

        // Random traffic with phases of varying backpressure
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 60 : 95);
            for (int n = 0; n < 400; n++) begin
                logic r;
                logic [3:0] c;
                r = ($urandom_range(0, 149) != 0);
                c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                step(r, 4'($urandom), c, ($urandom_range(0, 99) < rdy_pct));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
